answer_display: RTL and testbench
=================================

Name: answer_display

Overview:
- Downstream consumer of the chance-looper 7-bit `answer` result.
- Captures a 0..127 value on a valid strobe and converts it to three BCD digits with a sequential double-dabble (one shift per clock).
- Drives a time-multiplexed 3-digit seven-segment display with leading-zero blanking.
- Sits between the looper core and the board display pins.

Parameters:
- SCAN_DIV, 1000, clock cycles each digit stays enabled before the scan advances (minimum 2).
- SEG_ACTIVE_LOW, 1, 1 = `seg` bits are low-true; 0 = high-true.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- answer  in  7  binary value to display.
- answer_valid  in  1  one-cycle strobe; `answer` is sampled when this is high and `busy` is low.
- busy  out  1  conversion in progress; strobes are ignored while high.
- bcd  out  12  {hundreds, tens, ones}, 4 bits each, holds the last converted value.
- bcd_valid  out  1  one-cycle pulse when `bcd` updates.
- seg  out  7  segment pattern {g,f,e,d,c,b,a} for the enabled digit.
- an  out  3  one-hot digit enable, active-high; bit0 = ones, bit1 = tens, bit2 = hundreds.

Behaviour:
- Reset values (asynchronous, no clock needed):
  - FSM = IDLE; `busy` = 0; `bcd` = 0; `bcd_valid` = 0.
  - `loaded` flag = 0; scan divider = 0; digit index = 0; `an` = 3'b001.
  - `seg` = blank (all segments off under the active polarity).
- FSM states: IDLE, SHIFT, UPDATE.
  - IDLE: when `answer_valid` is high, load `answer` into the shift register, clear the BCD scratch to 0, set shift count = 7, go to SHIFT. `busy` = 1 from the next cycle.
  - SHIFT: each cycle, add 3 to every scratch digit >= 5, then shift {scratch, shreg} left 1. Decrement the count; after the 7th shift, go to UPDATE.
  - UPDATE: copy scratch to `bcd`, pulse `bcd_valid`, set `loaded` = 1, go to IDLE. `busy` = 0 in the cycle where `bcd_valid` = 1.
- Latency: `bcd`/`bcd_valid` are visible in the cycle after the 9th rising edge, counting the sampling edge as edge 0. Throughput is one conversion per 9 cycles.
  - A strobe in the same cycle `bcd_valid` is high is accepted.
- A strobe while `busy` = 1 is dropped silently; the in-flight conversion is unaffected.
- `bcd` holds its value between conversions; the display always shows the registered `bcd`, never the scratch.
- Scan:
  - The divider counts 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→0 and `an` rotates 001→010→100→001.
  - The scan is free-running and independent of the FSM.
- Blanking:
  - While `loaded` = 0, every digit is blank.
  - Hundreds is blank when it is 0.
  - Tens is blank when hundreds and tens are both 0.
  - Ones is always shown.
- Segment codes, high-true gfedcba:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, blank=00.
  - With SEG_ACTIVE_LOW = 1 the output is the bitwise inverse.
  - `seg` is registered and changes in the same cycle as `an`.
- Input range: every 7-bit input is valid (max 127), so BCD digits never exceed 9 and hundreds never exceeds 1.
- Reset mid-conversion: the conversion is abandoned, the display blanks, and `loaded` clears.

Decomposition:
- Package `answer_display_pkg`:
  - state enum {IDLE, SHIFT, UPDATE};
  - NUM_DIGITS = 3; SHIFT_STEPS = 7;
  - SEG_LUT constant for digits 0..9 and SEG_BLANK (high-true).
- Natural sub-module: `bin2bcd_seq`, the sequential double-dabble with start/busy/done and the 12-bit result. The parent owns capture, `bcd` register, blanking and scan.

Test Plan (SCAN_DIV=4, SEG_ACTIVE_LOW=1):
- Reset, then strobe answer=127 → `busy` high 8 cycles; `bcd` = 12'h127 with a 1-cycle `bcd_valid`. Scan gives `an` 001/010/100 with `seg` = 7'h78 / 7'h24 / 7'h79 ("7", "2", "1"), each held 4 cycles.
- Strobe answer=45 → `bcd` = 12'h045. Hundreds `seg` = 7'h7F (blank); tens = 7'h19 ("4"); ones = 7'h12 ("5").
- Strobe answer=0 → `bcd` = 12'h000. Only the ones digit is lit, with `seg` = 7'h40; hundreds and tens are 7'h7F.
- Strobe 100, then strobe 7 three cycles later → second strobe ignored; `bcd` = 12'h100 and only one `bcd_valid` pulse. A strobe of 7 in the `bcd_valid` cycle is accepted and gives 12'h007 nine cycles later.
- Assert reset at cycle 4 of a conversion of 99 → outputs return to reset values immediately. No `bcd_valid` is seen, and all digits stay blank until the next completed conversion.
- Before any strobe after reset → `an` rotates every 4 cycles and `seg` stays 7'h7F on all digits.

Source files
------------

// File: rtl/answer_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : answer_display_pkg
//  Description : Shared types, sizes and seven-segment encoding for the
//                answer display block.
//  Revision    : 1.0 - initial release
// ============================================================================
package answer_display_pkg;

   // Converter sequencing states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_UPDATE = 2'd2
   } state_t;

   localparam int NUM_DIGITS  = 3;
   localparam int SHIFT_STEPS = 7;

   // High-true gfedcba patterns, entry N is digit N
   localparam logic [6:0] SEG_BLANK = 7'h00;
   localparam logic [9:0][6:0] SEG_LUT = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // Map a BCD digit to its high-true pattern; non-decimal codes show blank
   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] pattern;
      pattern = SEG_BLANK;
      if (digit <= 4'd9) begin
         pattern = SEG_LUT[digit];
      end
      return pattern;
   endfunction

endpackage
`default_nettype wire

// File: rtl/answer_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : answer_display_if
//  Description : Value/strobe input, conversion status and display pins of
//                the answer display block.
//  Revision    : 1.0 - initial release
// ============================================================================
interface answer_display_if;

   logic [6:0]  answer;
   logic        answer_valid;
   logic        busy;
   logic [11:0] bcd;
   logic        bcd_valid;
   logic [6:0]  seg;
   logic [2:0]  an;

   // Producer side: the looper core / testbench
   modport master (
      output answer, answer_valid,
      input  busy, bcd, bcd_valid, seg, an
   );

   // The display block itself
   modport slave (
      input  answer, answer_valid,
      output busy, bcd, bcd_valid, seg, an
   );

endinterface
`default_nettype wire

// File: rtl/answer_display_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_seq
//  Description : Sequential double-dabble, 7-bit binary to three BCD digits,
//                one shift per clock. done is high for the single cycle in
//                which result carries the finished conversion.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
   import answer_display_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        start,
   input  wire logic [6:0]  bin,
   output logic             busy,
   output logic             done,
   output logic [11:0]      result
);

   localparam logic [2:0] STEPS = 3'(SHIFT_STEPS);

   state_t      r_state;
   state_t      w_state_next;
   logic [6:0]  r_shreg;
   logic [11:0] r_scratch;
   logic [2:0]  r_count;
   logic [11:0] w_adjusted;

   // Add 3 to every scratch digit that would overflow past 9 after doubling
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_adjust
      assign w_adjusted[4*i +: 4] = (r_scratch[4*i +: 4] >= 4'd5)
                                  ? r_scratch[4*i +: 4] + 4'd3
                                  : r_scratch[4*i +: 4];
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and status outputs
   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy = 1'b1;
            if (r_count == 3'd1) begin
               w_state_next = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            busy         = 1'b1;
            done         = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Shift register, BCD scratch and step counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shreg   <= '0;
         r_scratch <= '0;
         r_count   <= '0;
      end else if (r_state == ST_IDLE && start) begin
         r_shreg   <= bin;
         r_scratch <= '0;
         r_count   <= STEPS;
      end else if (r_state == ST_SHIFT) begin
         r_scratch <= {w_adjusted[10:0], r_shreg[6]};
         r_shreg   <= {r_shreg[5:0], 1'b0};
         r_count   <= r_count - 3'd1;
      end
   end

   assign result = r_scratch;

endmodule
`default_nettype wire

// File: rtl/answer_display.sv
`default_nettype none
// ============================================================================
//  Module      : answer_display
//  Description : Captures a 7-bit answer, converts it to BCD and drives a
//                multiplexed 3-digit seven-segment display with leading-zero
//                blanking.
//  Revision    : 1.0 - initial release
// ============================================================================
module answer_display
   import answer_display_pkg::*;
#(
   parameter int SCAN_DIV       = 1000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
)
(
   input  wire logic          clk,
   input  wire logic          reset,
   answer_display_if.slave    bus
);

   localparam int              DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [6:0]      SEG_OFF  = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

   logic             w_conv_busy;
   logic             w_conv_done;
   logic [11:0]      w_conv_result;

   logic [11:0]      r_bcd;
   logic             r_bcd_valid;
   logic             r_loaded;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_digit;
   logic [2:0]       r_an;
   logic [6:0]       r_seg;

   logic             w_wrap;
   logic [1:0]       w_digit_next;
   logic [3:0]       w_digit_val;
   logic             w_blank;
   logic [6:0]       w_seg_true;

   // Strobes arriving while busy are ignored inside the converter
   bin2bcd_seq u_bin2bcd (
      .clk    (clk),
      .reset  (reset),
      .start  (bus.answer_valid),
      .bin    (bus.answer),
      .busy   (w_conv_busy),
      .done   (w_conv_done),
      .result (w_conv_result)
   );

   // Publish the finished conversion and remember that something is shown
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bcd       <= '0;
         r_bcd_valid <= 1'b0;
         r_loaded    <= 1'b0;
      end else begin
         r_bcd_valid <= w_conv_done;
         if (w_conv_done) begin
            r_bcd    <= w_conv_result;
            r_loaded <= 1'b1;
         end
      end
   end

   assign w_wrap       = (r_div == DIV_LAST);
   assign w_digit_next = !w_wrap          ? r_digit :
                         (r_digit == 2'd2) ? 2'd0    : r_digit + 2'd1;

   // Pattern for the digit that will be enabled after this edge
   always_comb begin
      w_digit_val = r_bcd[3:0];
      w_blank     = !r_loaded;
      case (w_digit_next)
         2'd1: begin
            w_digit_val = r_bcd[7:4];
            w_blank     = !r_loaded || (r_bcd[11:4] == 8'h00);
         end
         2'd2: begin
            w_digit_val = r_bcd[11:8];
            w_blank     = !r_loaded || (r_bcd[11:8] == 4'h0);
         end
         default: begin
            w_digit_val = r_bcd[3:0];
            w_blank     = !r_loaded;
         end
      endcase
      w_seg_true = w_blank ? SEG_BLANK : seg_encode(w_digit_val);
   end

   // Free-running digit scan; seg is registered alongside an
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div   <= '0;
         r_digit <= 2'd0;
         r_an    <= 3'b001;
         r_seg   <= SEG_OFF;
      end else begin
         r_div   <= w_wrap ? '0 : r_div + DIV_W'(1);
         r_digit <= w_digit_next;
         if (w_wrap) begin
            r_an <= {r_an[1:0], r_an[2]};
         end
         r_seg <= SEG_ACTIVE_LOW ? ~w_seg_true : w_seg_true;
      end
   end

   assign bus.busy      = w_conv_busy;
   assign bus.bcd       = r_bcd;
   assign bus.bcd_valid = r_bcd_valid;
   assign bus.seg       = r_seg;
   assign bus.an        = r_an;

endmodule
`default_nettype wire

// File: tb/tb_answer_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_answer_display
//  Description : Self-checking bench for answer_display (SCAN_DIV=4,
//                active-low segments) with a decimal reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_answer_display;

   localparam int SCAN_DIV = 4;

   logic clk;
   logic reset;
   int   total;
   int   passed;

   // Reference model state: what the display should currently be holding
   logic [11:0] exp_bcd;
   logic        exp_loaded;

   answer_display_if bus ();

   answer_display #(
      .SCAN_DIV       (SCAN_DIV),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Active-low pattern for display position idx (0 ones, 1 tens, 2 hundreds)
   function automatic logic [6:0] exp_seg(input int idx);
      logic [3:0] d;
      logic       blank;
      logic [6:0] p;
      d     = exp_bcd[4*idx +: 4];
      blank = !exp_loaded
            || (idx == 2 && exp_bcd[11:8] == 4'd0)
            || (idx == 1 && exp_bcd[11:4] == 8'd0);
      case (d)
         4'd0: p = 7'h3F;  4'd1: p = 7'h06;  4'd2: p = 7'h5B;
         4'd3: p = 7'h4F;  4'd4: p = 7'h66;  4'd5: p = 7'h6D;
         4'd6: p = 7'h7D;  4'd7: p = 7'h07;  4'd8: p = 7'h7F;
         4'd9: p = 7'h6F;  default: p = 7'h00;
      endcase
      if (blank) p = 7'h00;
      return ~p;
   endfunction

   // Align to a digit change, then follow three full digit periods
   task automatic scan_check(input string tag);
      logic [2:0] start;
      int         n;
      int         idx0;
      int         idx;
      start = bus.an;
      n = 0;
      while (bus.an === start && n < 3 * SCAN_DIV) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_an_advances"}, 32'(n < 3 * SCAN_DIV), 32'd1);
      start = bus.an;
      chk({tag, "_an_onehot"}, 32'(start == 3'b001 || start == 3'b010 || start == 3'b100), 32'd1);
      idx0 = (start == 3'b010) ? 1 : (start == 3'b100) ? 2 : 0;
      for (int i = 0; i < 3 * SCAN_DIV; i++) begin
         idx = (idx0 + i / SCAN_DIV) % 3;
         chk({tag, "_an"},  32'(bus.an),  32'(3'b001 << idx));
         chk({tag, "_seg"}, 32'(bus.seg), 32'(exp_seg(idx)));
         @(negedge clk);
      end
   endtask

   // Strobe v; optionally fire a stray strobe stray_at cycles later
   task automatic convert(input logic [6:0] v, input int stray_at);
      int n;
      int bc;
      bus.answer       = v;
      bus.answer_valid = 1'b1;
      @(negedge clk);
      n  = 1;
      bc = 0;
      while (bus.bcd_valid !== 1'b1 && n < 20) begin
         bus.answer_valid = (n == stray_at);
         if (n == stray_at) bus.answer = 7'($urandom);
         if (bus.busy === 1'b1) bc++;
         @(negedge clk);
         n++;
      end
      bus.answer_valid = 1'b0;
      exp_bcd    = to_bcd(int'(v));
      exp_loaded = 1'b1;
      chk("latency",       32'(n),        32'd9);
      chk("busy_cycles",   32'(bc),       32'd8);
      chk("bcd",           32'(bus.bcd),  32'(exp_bcd));
      chk("busy_at_valid", 32'(bus.busy), 32'd0);
      @(negedge clk);
      chk("bcd_valid_pulse", 32'(bus.bcd_valid), 32'd0);
      chk("bcd_hold",        32'(bus.bcd),       32'(exp_bcd));
   endtask

   initial begin
      int pulses;
      total            = 0;
      passed           = 0;
      exp_bcd          = '0;
      exp_loaded       = 1'b0;
      reset            = 1'b0;
      bus.answer       = '0;
      bus.answer_valid = 1'b0;

      // Asynchronous reset, checked before any clock edge
      #2 reset = 1'b1;
      #1;
      chk("rst_busy",      32'(bus.busy),      32'd0);
      chk("rst_bcd",       32'(bus.bcd),       32'd0);
      chk("rst_bcd_valid", 32'(bus.bcd_valid), 32'd0);
      chk("rst_an",        32'(bus.an),        32'b001);
      chk("rst_seg",       32'(bus.seg),       32'h7F);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      scan_check("preload");

      convert(7'd127, 0);
      scan_check("v127");
      convert(7'd45, 0);
      scan_check("v45");
      convert(7'd0, 0);
      scan_check("v0");

      // Strobe during busy is dropped; strobe in the bcd_valid cycle is taken
      bus.answer       = 7'd100;
      bus.answer_valid = 1'b1;
      @(negedge clk);
      pulses = 0;
      for (int k = 1; k <= 8; k++) begin
         bus.answer_valid = (k == 3);
         if (k == 3) bus.answer = 7'd7;
         if (bus.bcd_valid === 1'b1) pulses++;
         @(negedge clk);
      end
      bus.answer_valid = 1'b0;
      exp_bcd    = to_bcd(100);
      exp_loaded = 1'b1;
      chk("drop_valid",  32'(bus.bcd_valid), 32'd1);
      chk("drop_bcd",    32'(bus.bcd),       32'(exp_bcd));
      bus.answer       = 7'd7;
      bus.answer_valid = 1'b1;
      @(negedge clk);
      for (int k = 1; k <= 8; k++) begin
         bus.answer_valid = 1'b0;
         if (bus.bcd_valid === 1'b1) pulses++;
         @(negedge clk);
      end
      exp_bcd = to_bcd(7);
      chk("drop_pulses",    32'(pulses),        32'd0);
      chk("back2back_valid", 32'(bus.bcd_valid), 32'd1);
      chk("back2back_bcd",  32'(bus.bcd),       32'(exp_bcd));
      @(negedge clk);
      scan_check("v7");

      // Reset in the middle of converting 99
      bus.answer       = 7'd99;
      bus.answer_valid = 1'b1;
      @(negedge clk);
      bus.answer_valid = 1'b0;
      for (int k = 0; k < 3; k++) @(negedge clk);
      reset = 1'b1;
      #1;
      exp_bcd    = '0;
      exp_loaded = 1'b0;
      chk("midrst_busy",      32'(bus.busy),      32'd0);
      chk("midrst_bcd",       32'(bus.bcd),       32'd0);
      chk("midrst_bcd_valid", 32'(bus.bcd_valid), 32'd0);
      chk("midrst_an",        32'(bus.an),        32'b001);
      chk("midrst_seg",       32'(bus.seg),       32'h7F);
      @(negedge clk);
      reset  = 1'b0;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         if (bus.bcd_valid === 1'b1) pulses++;
         @(negedge clk);
      end
      chk("midrst_no_valid", 32'(pulses),  32'd0);
      chk("midrst_bcd_hold", 32'(bus.bcd), 32'd0);
      scan_check("midrst_blank");

      // Randomized conversions, some with a stray strobe while busy
      for (int r = 0; r < 8; r++) begin
         int gap;
         convert(7'($urandom_range(0, 127)), int'($urandom_range(0, 8)));
         gap = int'($urandom_range(0, 3));
         for (int g = 0; g < gap; g++) @(negedge clk);
         scan_check("rand");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
